native_mem_mmio_slave: RTL and testbench
========================================

Name: native_mem_mmio_slave

Overview:
- Parametrised slave for the picorv32 native memory interface (mem_valid/mem_ready). Successor to the fixed 1 KB zero-wait testbench memory.
- Provides a word-addressed RAM of configurable depth and a programmable number of wait states.
- Adds a small MMIO window: GPIO output register and console byte port.
- Flags unmapped accesses with a sticky bus error instead of hanging the core.

Parameters:
- MEM_WORDS, 1828, RAM depth in 32-bit words; RAM spans byte addresses 0 .. 4*MEM_WORDS-1.
- WAIT_STATES, 0, extra cycles inserted before mem_ready (0..15).
- IO_BASE, 32'h1000_0000, byte base of the MMIO window (16 bytes, 4 words).
- GPIO_W, 8, width of gpio_out (1..32).
- INIT_FILE, "firmware.hex", $readmemh image loaded at time 0; no load if empty string.

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  request valid, held by master until mem_ready
- mem_instr  in  1  instruction fetch qualifier; informational, no behavioural effect
- mem_ready  out  1  one-cycle response strobe
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write enables; 0 = read
- mem_rdata  out  32  read data, valid while mem_ready=1
- gpio_out  out  GPIO_W  GPIO output register
- con_valid  out  1  one-cycle strobe, console byte written
- con_data  out  8  console byte, held until next console write
- bus_err  out  1  sticky unmapped-access flag

Behaviour:
- Reset (async assert, sync deassert by caller):
  - mem_ready=0, mem_rdata=0, gpio_out=0, con_valid=0, con_data=0, bus_err=0, FSM=IDLE, wait counter=0.
  - RAM contents are not reset.
- FSM states:
  - IDLE: on mem_valid=1, latch addr/wdata/wstrb, load cnt=WAIT_STATES, go to WAIT if WAIT_STATES>0, else go straight to RESP actions.
  - WAIT: decrement cnt each cycle; when cnt reaches 1, next edge performs RESP actions.
  - RESP: mem_ready=1 for exactly one cycle, then IDLE.
  - RESP→IDLE blocks re-acceptance for one cycle, so a valid still high in the ready cycle is never re-sampled.
- Latency: valid sampled at edge N → mem_ready high during cycle N+1+WAIT_STATES.
- Access commit: all writes and side effects happen at the edge that raises mem_ready. mem_rdata is loaded at that same edge.
- Decode, word = latched addr>>2:
  - RAM (addr < 4*MEM_WORDS):
    - Read returns RAM[word].
    - Write updates only the lanes enabled by wstrb; mem_rdata returns the pre-write word.
  - IO_BASE+0x0, GPIO: R/W. Byte lanes apply to the low GPIO_W bits; reads zero-extend.
  - IO_BASE+0x4, console:
    - A write with wstrb[0]=1 sets con_data=wdata[7:0] and pulses con_valid for one cycle, coincident with mem_ready.
    - Reads return 0.
  - IO_BASE+0x8: cycle counter (optional feature), else reads 0 and ignores writes.
  - IO_BASE+0xC: status. Read returns {31'b0,bus_err}. A write with wdata[0]=1 clears bus_err.
  - Anything else: mem_ready still asserted with the normal latency, mem_rdata=0, no write, bus_err set to 1.
- mem_wstrb=0 with a write-only target: treated as a read, no side effect.
- Reset mid-transaction (WAIT or RESP): return to IDLE immediately. An uncommitted write is discarded. No mem_ready is produced for the aborted request.
- RAM and MMIO ranges overlap only if misconfigured; RAM decode takes priority.

Optional Feature:
- Macro: NATIVE_MEM_CYCLE_COUNTER_EN.
- Defined:
  - 32-bit free-running counter, reset to 0, increments every clk and wraps 0xFFFFFFFF→0.
  - Read at IO_BASE+0x8 returns its value at the commit edge.
  - A write loads the counter with wdata (lanes per wstrb); counting resumes the next cycle.
- Undefined: no counter logic; IO_BASE+0x8 reads 0 and ignores writes; not treated as a bus error.

Test Plan:
- WAIT_STATES=0: write 0xA5A5_1234 to 0x10 (wstrb=F), then read 0x10 → rdata=0xA5A5_1234; ready exactly one cycle after valid is sampled.
- Byte lanes: RAM[4]=0x11223344; write wdata=0xFFEEDDCC, wstrb=4'b0101 to 0x10 → read returns 0x11EE33CC.
- WAIT_STATES=3: read RAM → ready during cycle N+4; valid held throughout, no second ready; next request accepted only after the one-cycle gap.
- Console write of 0x41 to IO_BASE+4 → con_valid pulse of 1 cycle with con_data=0x41. Read of 0x2000_0000 → ready, rdata=0, bus_err=1. Write of 1 to IO_BASE+0xC → bus_err=0.
- resetn low while in WAIT with a pending RAM write → no ready; RAM unchanged; gpio_out=0; FSM in IDLE accepts the next request normally.
- With NATIVE_MEM_CYCLE_COUNTER_EN: write 0xFFFF_FFFE to IO_BASE+8, read it back 4 cycles later → wrapped value consistent with elapsed cycles. Without the macro → read 0, bus_err stays 0.

Source files
------------

// File: rtl/native_mem_mmio_slave.sv
// native_mem_mmio_slave: picorv32 native-bus slave with a word RAM, programmable
// wait states and a 4-word MMIO window (GPIO, console byte port, cycle counter,
// status). Unmapped accesses still complete but raise a sticky bus error.
// Build option: define NATIVE_MEM_CYCLE_COUNTER_EN to include the free-running
// cycle counter at IO_BASE+0x8. Without it, that register reads 0 and ignores writes.
module native_mem_mmio_slave #(
  parameter int unsigned MEM_WORDS   = 1828,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] IO_BASE     = 32'h1000_0000,
  parameter int unsigned GPIO_W      = 8,
  parameter string       INIT_FILE   = "firmware.hex"
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  output logic              mem_ready,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              con_valid,
  output logic [7:0]        con_data,
  output logic              bus_err
);

  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT_STATES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] REG_GPIO = 2'd0;
  localparam logic [1:0] REG_CON  = 2'd1;
  localparam logic [1:0] REG_CYC  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  // Replace the byte lanes of old_w selected by strb with the lanes of new_w.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end
    end
    return res;
  endfunction

  // FSM and latched request
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        commit_s;

  // Registered outputs
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic              con_valid_q, con_valid_d;
  logic [7:0]        con_data_q, con_data_d;
  logic              bus_err_q, bus_err_d;

  // Access view: live inputs when committing straight from IDLE, latched otherwise
  logic [31:0]   acc_addr_s;
  logic [31:0]   acc_wdata_s;
  logic [3:0]    acc_wstrb_s;
  logic [AW-1:0] word_s;
  logic          ram_hit_s;
  logic          io_hit_s;
  logic [1:0]    reg_sel_s;
  logic          wr_s;
  logic [31:0]   rd_s;
  logic [31:0]   gpio32_s;
  logic [31:0]   gpio_mrg_s;
  logic          ram_we_s;

  logic [31:0] ram_q [MEM_WORDS];

`ifdef NATIVE_MEM_CYCLE_COUNTER_EN
  logic [31:0] cyc_q;
  logic        cyc_we_s;
  logic [31:0] cyc_mrg_s;
  assign cyc_mrg_s = lane_merge(cyc_q, acc_wdata_s, acc_wstrb_s);
`endif

  assign acc_addr_s  = (state_q == ST_IDLE) ? mem_addr  : addr_q;
  assign acc_wdata_s = (state_q == ST_IDLE) ? mem_wdata : wdata_q;
  assign acc_wstrb_s = (state_q == ST_IDLE) ? mem_wstrb : wstrb_q;
  assign word_s      = acc_addr_s[AW+1:2];
  assign ram_hit_s   = (acc_addr_s < RAM_BYTES);
  assign io_hit_s    = (acc_addr_s[31:4] == IO_BASE[31:4]) && !ram_hit_s;
  assign reg_sel_s   = acc_addr_s[3:2];
  assign wr_s        = |acc_wstrb_s;
  assign gpio32_s    = 32'(gpio_q);
  assign gpio_mrg_s  = lane_merge(gpio32_s, acc_wdata_s, acc_wstrb_s);

  // mem_instr and the byte offset carry no behaviour
  logic unused_s;
  assign unused_s = ^{mem_instr, acc_addr_s[1:0]};

  // Next-state logic: accept in IDLE, count down wait states, one RESP cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          cnt_d   = WAIT_LD;
          if (WAIT_STATES == 0) begin
            commit_s = 1'b1;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          commit_s = 1'b1;
          cnt_d    = 4'd0;
          state_d  = ST_RESP;
        end else begin
          cnt_d    = cnt_q - 4'd1;
        end
      end
      // Ready cycle; the request is not re-sampled here
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-data mux for the addressed target
  always_comb begin
    rd_s = 32'h0000_0000;
    if (ram_hit_s) begin
      rd_s = ram_q[word_s];
    end else if (io_hit_s) begin
      case (reg_sel_s)
        REG_GPIO: rd_s = gpio32_s;
        REG_CON:  rd_s = 32'h0000_0000;
`ifdef NATIVE_MEM_CYCLE_COUNTER_EN
        REG_CYC:  rd_s = cyc_q;
`else
        REG_CYC:  rd_s = 32'h0000_0000;
`endif
        REG_STAT: rd_s = {31'h0000_0000, bus_err_q};
        default:  rd_s = 32'h0000_0000;
      endcase
    end else begin
      rd_s = 32'h0000_0000;
    end
  end

  // Commit actions: every write and side effect lands on the edge raising mem_ready
  always_comb begin
    ready_d     = commit_s;
    rdata_d     = rdata_q;
    gpio_d      = gpio_q;
    con_valid_d = 1'b0;
    con_data_d  = con_data_q;
    bus_err_d   = bus_err_q;
    ram_we_s    = 1'b0;
`ifdef NATIVE_MEM_CYCLE_COUNTER_EN
    cyc_we_s    = 1'b0;
`endif
    if (commit_s) begin
      rdata_d = rd_s;
      if (ram_hit_s) begin
        ram_we_s = wr_s;
      end else if (io_hit_s) begin
        case (reg_sel_s)
          REG_GPIO: begin
            if (wr_s) begin
              gpio_d = gpio_mrg_s[GPIO_W-1:0];
            end else begin
              gpio_d = gpio_q;
            end
          end
          REG_CON: begin
            if (acc_wstrb_s[0]) begin
              con_valid_d = 1'b1;
              con_data_d  = acc_wdata_s[7:0];
            end else begin
              con_valid_d = 1'b0;
            end
          end
          REG_CYC: begin
`ifdef NATIVE_MEM_CYCLE_COUNTER_EN
            cyc_we_s = wr_s;
`endif
          end
          REG_STAT: begin
            if (wr_s && acc_wdata_s[0]) begin
              bus_err_d = 1'b0;
            end else begin
              bus_err_d = bus_err_q;
            end
          end
          default: bus_err_d = bus_err_q;
        endcase
      end else begin
        bus_err_d = 1'b1;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and output registers; reset aborts any in-flight request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      wstrb_q     <= 4'h0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      gpio_q      <= '0;
      con_valid_q <= 1'b0;
      con_data_q  <= 8'h00;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      gpio_q      <= gpio_d;
      con_valid_q <= con_valid_d;
      con_data_q  <= con_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[word_s] <= lane_merge(ram_q[word_s], acc_wdata_s, acc_wstrb_s);
    end
  end

`ifdef NATIVE_MEM_CYCLE_COUNTER_EN
  // Free-running cycle counter; a bus write loads it, counting resumes next cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc_q <= 32'h0000_0000;
    end else if (cyc_we_s) begin
      cyc_q <= cyc_mrg_s;
    end else begin
      cyc_q <= cyc_q + 32'd1;
    end
  end
`endif

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign gpio_out  = gpio_q;
  assign con_valid = con_valid_q;
  assign con_data  = con_data_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_native_mem_mmio_slave.sv
// Randomized self-checking bench for native_mem_mmio_slave. Two instances share
// the clock/reset: dut0 with zero wait states, dut1 with three wait states.
module tb_native_mem_mmio_slave;

  localparam logic [31:0] IO  = 32'h1000_0000;
  localparam int          MW0 = 1828;
  localparam int          MW1 = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        valid_a [2];
  logic        instr_a [2];
  logic [31:0] addr_a  [2];
  logic [31:0] wdata_a [2];
  logic [3:0]  wstrb_a [2];
  logic        ready_a [2];
  logic [31:0] rdata_a [2];
  logic        conv_a  [2];
  logic [7:0]  cond_a  [2];
  logic        berr_a  [2];
  logic [7:0]  gpio0;
  logic [11:0] gpio1;

  native_mem_mmio_slave #(.MEM_WORDS(MW0), .WAIT_STATES(0), .IO_BASE(IO),
                          .GPIO_W(8), .INIT_FILE("")) u_dut0 (
    .clk(clk), .resetn(resetn), .mem_valid(valid_a[0]), .mem_instr(instr_a[0]),
    .mem_ready(ready_a[0]), .mem_addr(addr_a[0]), .mem_wdata(wdata_a[0]),
    .mem_wstrb(wstrb_a[0]), .mem_rdata(rdata_a[0]), .gpio_out(gpio0),
    .con_valid(conv_a[0]), .con_data(cond_a[0]), .bus_err(berr_a[0]));

  native_mem_mmio_slave #(.MEM_WORDS(MW1), .WAIT_STATES(3), .IO_BASE(IO),
                          .GPIO_W(12), .INIT_FILE("")) u_dut1 (
    .clk(clk), .resetn(resetn), .mem_valid(valid_a[1]), .mem_instr(instr_a[1]),
    .mem_ready(ready_a[1]), .mem_addr(addr_a[1]), .mem_wdata(wdata_a[1]),
    .mem_wstrb(wstrb_a[1]), .mem_rdata(rdata_a[1]), .gpio_out(gpio1),
    .con_valid(conv_a[1]), .con_data(cond_a[1]), .bus_err(berr_a[1]));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [31:0] gpio_m [2];
  logic        berr_m [2];
  logic [7:0]  cond_m [2];
  logic [31:0] cyc_base_m [2];
  int unsigned cyc_edge_m [2];
  bit          cyc_known_m [2];
  int unsigned ws_of [2] = '{0, 3};
  int unsigned mw_of [2] = '{MW0, MW1};
  int unsigned gw_of [2] = '{8, 12};

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gpio_val(input int d);
    return (d == 0) ? 32'(gpio0) : 32'(gpio1);
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      gpio_m[d] = 32'h0; berr_m[d] = 1'b0; cond_m[d] = 8'h00; cyc_known_m[d] = 1'b0;
    end
  endfunction

  // Behavioural effect of one access committed at edge ce
  function automatic void model(input int d, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] ws, input int unsigned ce,
                                output logic [31:0] er, output bit rchk, output bit cev);
    int key;
    logic [31:0] cur;
    logic [63:0] m64;
    er = 32'h0; rchk = 1'b1; cev = 1'b0;
    if (a < 32'(4 * mw_of[d])) begin
      key = d * 100000 + int'(a >> 2);
      if (ram_m.exists(key)) begin cur = ram_m[key]; er = cur; end
      else begin cur = 32'h0; rchk = 1'b0; end
      for (int b = 0; b < 4; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
      if (ws != 4'h0 && (rchk || ws == 4'hF)) ram_m[key] = cur;
    end else if (a[31:4] == IO[31:4]) begin
      case (a[3:2])
        2'd0: begin
          er = gpio_m[d]; cur = gpio_m[d];
          for (int b = 0; b < 4; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
          m64 = (64'd1 << gw_of[d]) - 64'd1;
          gpio_m[d] = cur & m64[31:0];
        end
        2'd1: if (ws[0]) begin cond_m[d] = wd[7:0]; cev = 1'b1; end
        2'd2: begin
`ifdef NATIVE_MEM_CYCLE_COUNTER_EN
          cur = cyc_base_m[d] + 32'(ce - cyc_edge_m[d] - 1);
          er = cur; rchk = cyc_known_m[d];
          if (ws != 4'h0) begin
            for (int b = 0; b < 4; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
            cyc_known_m[d] = cyc_known_m[d] || (ws == 4'hF);
            cyc_base_m[d] = cur; cyc_edge_m[d] = ce;
          end
`else
          er = 32'h0;
`endif
        end
        default: begin
          er = {31'h0, berr_m[d]};
          if (ws != 4'h0 && wd[0]) berr_m[d] = 1'b0;
        end
      endcase
    end else begin
      berr_m[d] = 1'b1;
    end
  endfunction

  // One bus transaction, called and returning on a falling edge
  task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd);
    int lat;
    logic [31:0] er;
    bit rchk, cev;
    valid_a[d] = 1'b1; addr_a[d] = a; wdata_a[d] = wd; wstrb_a[d] = ws;
    instr_a[d] = 1'($urandom_range(0, 1));
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ready_a[d]) begin lat = i; break; end
    end
    rd = rdata_a[d];
    if (lat == 0) begin
      check("ready_timeout", 32'h0, 32'h1);
      valid_a[d] = 1'b0; wstrb_a[d] = 4'h0;
      return;
    end
    model(d, a, wd, ws, edge_cnt, er, rchk, cev);
    check("latency", 32'(lat), 32'(1 + ws_of[d]));
    if (rchk) check("rdata", rd, er);
    check("con_valid", 32'(conv_a[d]), 32'(cev));
    check("con_data", 32'(cond_a[d]), 32'(cond_m[d]));
    check("bus_err", 32'(berr_a[d]), 32'(berr_m[d]));
    check("gpio", gpio_val(d), gpio_m[d]);
    // valid is still held across the ready cycle; there must be no second ready
    @(negedge clk);
    check("ready_gap", 32'(ready_a[d]), 32'h0);
    check("con_pulse", 32'(conv_a[d]), 32'h0);
    valid_a[d] = 1'b0; wstrb_a[d] = 4'h0;
  endtask

  function automatic logic [31:0] pool_addr(input int d, input int idx);
    int w;
    w = (idx < 16) ? idx : int'(mw_of[d]) - 18 + idx;
    return 32'(4 * w);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, old;
    int kind;
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid_a[d] = 1'b0; instr_a[d] = 1'b0; addr_a[d] = 32'h0;
      wdata_a[d] = 32'h0; wstrb_a[d] = 4'h0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(ready_a[d]), 32'h0);
      check("rst_rdata", rdata_a[d], 32'h0);
      check("rst_gpio", gpio_val(d), 32'h0);
      check("rst_conv", 32'(conv_a[d]), 32'h0);
      check("rst_cond", 32'(cond_a[d]), 32'h0);
      check("rst_berr", 32'(berr_a[d]), 32'h0);
    end
    resetn = 1'b1;
    @(negedge clk);

    // Directed: zero-wait write/read and byte lanes
    access(0, 32'h10, 32'hA5A5_1234, 4'hF, rd);
    access(0, 32'h10, 32'h0, 4'h0, rd);
    check("ws0_read", rd, 32'hA5A5_1234);
    access(0, 32'h10, 32'h1122_3344, 4'hF, rd);
    access(0, 32'h10, 32'hFFEE_DDCC, 4'b0101, rd);
    check("lane_prewrite", rd, 32'h1122_3344);
    access(0, 32'h10, 32'h0, 4'h0, rd);
    check("lane_merge", rd, 32'h11EE_33CC);

    // Directed: console, unmapped, status clear, RAM boundary
    access(0, IO + 32'h4, 32'h0000_0041, 4'h1, rd);
    check("con_held", 32'(cond_a[0]), 32'h41);
    access(0, 32'h2000_0000, 32'h0, 4'h0, rd);
    check("unmapped_rdata", rd, 32'h0);
    check("unmapped_err", 32'(berr_a[0]), 32'h1);
    access(0, IO + 32'hC, 32'h0, 4'h0, rd);
    check("status_read", rd, 32'h1);
    access(0, IO + 32'hC, 32'h1, 4'hF, rd);
    check("status_clear", 32'(berr_a[0]), 32'h0);
    access(0, 32'(4 * MW0 - 4), 32'hDEAD_BEEF, 4'hF, rd);
    access(0, 32'(4 * MW0 - 4), 32'h0, 4'h0, rd);
    check("ram_last_word", rd, 32'hDEAD_BEEF);
    access(0, 32'(4 * MW0), 32'h0, 4'h0, rd);
    check("ram_end_err", 32'(berr_a[0]), 32'h1);
    access(0, IO + 32'hC, 32'h1, 4'h1, rd);

    // Directed: three wait states
    access(1, 32'h10, 32'h1234_5678, 4'hF, rd);
    access(1, 32'h10, 32'h0, 4'h0, rd);
    check("ws3_read", rd, 32'h1234_5678);

    // Prefill the RAM address pools, then random traffic
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 18; i++) access(d, pool_addr(d, i), $urandom, 4'hF, rd);
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 120; n++) begin
        kind = $urandom_range(0, 9);
        case (kind)
          6: access(d, IO, $urandom, 4'($urandom_range(0, 15)), rd);
          7: access(d, IO + 32'h4, $urandom, 4'($urandom_range(0, 15)), rd);
          8: access(d, IO + 32'hC, $urandom, 4'($urandom_range(0, 15)), rd);
          9: begin
            case ($urandom_range(0, 3))
              0: access(d, 32'(4 * mw_of[d]), $urandom, 4'($urandom_range(0, 15)), rd);
              1: access(d, IO + 32'h10, $urandom, 4'($urandom_range(0, 15)), rd);
              2: access(d, 32'h2000_0000, $urandom, 4'($urandom_range(0, 15)), rd);
              default: access(d, 32'h4000_0000 | 32'($urandom_range(0, 65535)), $urandom,
                               4'($urandom_range(0, 15)), rd);
            endcase
          end
          default: access(d, pool_addr(d, $urandom_range(0, 17)), $urandom,
                          4'($urandom_range(0, 15)), rd);
        endcase
      end
    end

    // Reset while dut1 holds a RAM write in its wait states
    access(1, IO, 32'h0000_0ABC, 4'hF, rd);
    access(1, 32'h14, 32'h0, 4'h0, rd);
    old = ram_m[100000 + 5];
    valid_a[1] = 1'b1; addr_a[1] = 32'h14; wdata_a[1] = ~old; wstrb_a[1] = 4'hF;
    @(negedge clk);
    check("abort_wait1", 32'(ready_a[1]), 32'h0);
    @(negedge clk);
    check("abort_wait2", 32'(ready_a[1]), 32'h0);
    resetn = 1'b0;
    valid_a[1] = 1'b0; wstrb_a[1] = 4'h0;
    model_reset();
    @(negedge clk);
    check("abort_ready", 32'(ready_a[1]), 32'h0);
    check("abort_gpio", gpio_val(1), 32'h0);
    check("abort_berr", 32'(berr_a[1]), 32'h0);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_ready", 32'(ready_a[1]), 32'h0);
    end
    access(1, 32'h14, 32'h0, 4'h0, rd);
    check("abort_ram_kept", rd, old);
    access(1, 32'h18, 32'h5555_AAAA, 4'hF, rd);

    // Cycle counter register
`ifdef NATIVE_MEM_CYCLE_COUNTER_EN
    access(0, IO + 32'h8, 32'hFFFF_FFFE, 4'hF, rd);
    repeat (2) @(negedge clk);
    access(0, IO + 32'h8, 32'h0, 4'h0, rd);
    check("cyc_wrap", rd, 32'h0000_0001);
`else
    access(0, IO + 32'h8, 32'hFFFF_FFFE, 4'hF, rd);
    access(0, IO + 32'h8, 32'h0, 4'h0, rd);
    check("cyc_absent_read", rd, 32'h0);
    check("cyc_absent_berr", 32'(berr_a[0]), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
